// File: rtl/ntt_mem_responder.sv
// Round-robin memory responder: NUM_CORES requesters share one 64-bit word RAM.
// Optional grant counter on stat_grants is built when MEM_RESP_STATS_EN is defined.
module ntt_mem_responder #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 12,
    parameter int READ_LAT  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CORES-1:0]    mem_req,
    input  logic [NUM_CORES-1:0]    mem_we,
    input  logic [NUM_CORES*64-1:0] mem_addr,
    input  logic [NUM_CORES*64-1:0] mem_wdata,
    output logic [NUM_CORES-1:0]    mem_gnt,
    output logic [NUM_CORES-1:0]    mem_valid,
    output logic [NUM_CORES*64-1:0] mem_rdata,
    output logic [31:0]             err_count,
    output logic [31:0]             stat_grants
);
    localparam int CW    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int LAST  = READ_LAT - 1;

    logic [CW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]     sel, cand;
    logic              found, fire, oor;
    logic              rd_fire, wr_fire;
    logic              sel_we;
    logic [63:0]       sel_addr, sel_wdata;
    logic [ADDR_W-1:0] widx;
    logic [31:0]       err_q, err_d;
    logic              unused_lo;

    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cand = CW'((int'(rr_ptr_q) + i) % NUM_CORES);
            if (!found && mem_req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign fire      = found & ~rst;
    assign sel_we    = mem_we[sel];
    assign sel_addr  = mem_addr[sel*64 +: 64];
    assign sel_wdata = mem_wdata[sel*64 +: 64];
    assign oor       = |sel_addr[63:ADDR_W+3];
    assign widx      = sel_addr[ADDR_W+2:3];
    assign unused_lo = ^sel_addr[2:0];
    assign wr_fire   = fire & sel_we & ~oor;
    assign rd_fire   = fire & ~sel_we;
    assign mem_gnt   = fire ? (NUM_CORES'(1) << sel) : '0;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (fire) begin
            rr_ptr_d = (sel == CW'(NUM_CORES - 1)) ? '0 : sel + CW'(1);
        end
        err_d = err_q;
        if (fire && oor && err_q != 32'hFFFF_FFFF) begin
            err_d = err_q + 32'd1;
        end
    end

    assign err_count = err_q;

    // RAM contents survive reset; only the request side is cleared.
    logic [63:0] ram_q [DEPTH];
    logic [63:0] ram_rd_q;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            ram_q[widx] <= sel_wdata;
        end
        if (rd_fire) begin
            ram_rd_q <= ram_q[widx];
        end
    end

    logic [READ_LAT-1:0] pv_q, pv_d;
    logic [READ_LAT-1:0] po_q, po_d;
    logic [CW-1:0]       pc_q [READ_LAT];
    logic [CW-1:0]       pc_d [READ_LAT];
    logic [63:0]         out_data;

    always_comb begin
        pv_d[0] = rd_fire;
        po_d[0] = oor;
        pc_d[0] = sel;
        for (int j = 1; j < READ_LAT; j++) begin
            pv_d[j] = pv_q[j-1];
            po_d[j] = po_q[j-1];
            pc_d[j] = pc_q[j-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            err_q    <= '0;
            pv_q     <= '0;
            po_q     <= '0;
            for (int j = 0; j < READ_LAT; j++) begin
                pc_q[j] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
            pv_q     <= pv_d;
            po_q     <= po_d;
            pc_q     <= pc_d;
        end
    end

    // Data lanes need no reset: they are only visible under a valid bit.
    if (READ_LAT == 1) begin : g_lat1
        assign out_data = ram_rd_q;
    end else begin : g_latn
        logic [63:0] pd_q [READ_LAT-1];
        logic [63:0] pd_d [READ_LAT-1];

        always_comb begin
            pd_d[0] = ram_rd_q;
            for (int j = 1; j < READ_LAT - 1; j++) begin
                pd_d[j] = pd_q[j-1];
            end
        end

        always_ff @(posedge clk) begin
            pd_q <= pd_d;
        end

        assign out_data = pd_q[READ_LAT-2];
    end

    always_comb begin
        mem_valid = '0;
        mem_rdata = '0;
        if (pv_q[LAST] && !rst) begin
            mem_valid = NUM_CORES'(1) << pc_q[LAST];
            if (!po_q[LAST]) begin
                mem_rdata[pc_q[LAST]*64 +: 64] = out_data;
            end
        end
    end

`ifdef MEM_RESP_STATS_EN
    logic [31:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q + {31'd0, fire};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_grants = stat_q;
`else
    assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_ntt_mem_responder.sv
// Randomized bench for ntt_mem_responder against a transaction-level model.
// Model tracks memory words, grant order and a queue of due responses.
module tb_ntt_mem_responder;
    localparam int NC  = 4;
    localparam int AW  = 12;
    localparam int LAT = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NC-1:0]   mem_req, mem_we;
    logic [NC*64-1:0] mem_addr, mem_wdata;
    logic [NC-1:0]   mem_gnt, mem_valid;
    logic [NC*64-1:0] mem_rdata;
    logic [31:0]     err_count, stat_grants;

    ntt_mem_responder #(
        .NUM_CORES(NC),
        .ADDR_W   (AW),
        .READ_LAT (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_valid  (mem_valid),
        .mem_rdata  (mem_rdata),
        .err_count  (err_count),
        .stat_grants(stat_grants)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          core;
        logic [63:0] data;
    } resp_t;

    resp_t       q[$];
    logic [63:0] mem_m [int];
    int          rr_m;
    logic [31:0] err_m;
    logic [31:0] stat_m;
    int          cyc;
    int          n_chk;
    int          n_err;

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h want %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic idle();
        mem_req   = '0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
    endtask

    task automatic req(input int c, input bit we, input logic [63:0] a,
                       input logic [63:0] d);
        mem_req[c]           = 1'b1;
        mem_we[c]            = we;
        mem_addr[c*64 +: 64]  = a;
        mem_wdata[c*64 +: 64] = d;
    endtask

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        a = '0;
        a[AW+2:3] = AW'($urandom_range(0, 15));
        a[2:0] = 3'($urandom);
        if ($urandom_range(0, 9) == 0) begin
            a[$urandom_range(AW + 3, 63)] = 1'b1;
        end
        return a;
    endfunction

    task automatic step();
        logic [NC-1:0]   eg, ev, rq;
        logic [NC*64-1:0] er;
        logic [63:0]     a, d;
        int              k;
        bit              due_now;
        @(negedge clk);
        rq = mem_req;
        eg = '0;
        ev = '0;
        er = '0;
        k  = -1;
        if (!rst) begin
            for (int i = 0; i < NC; i++) begin
                int c;
                c = (rr_m + i) % NC;
                if (k < 0 && rq[c]) k = c;
            end
        end
        if (k >= 0) eg[k] = 1'b1;
        due_now = (q.size() > 0) && (q[0].due == cyc);
        if (due_now && !rst) begin
            ev[q[0].core] = 1'b1;
            er[q[0].core*64 +: 64] = q[0].data;
        end
        chk("gnt", 256'(mem_gnt), 256'(eg));
        chk("valid", 256'(mem_valid), 256'(ev));
        chk("rdata", 256'(mem_rdata), 256'(er));
        chk("err_count", 256'(err_count), 256'(err_m));
        chk("stat_grants", 256'(stat_grants), 256'(stat_m));
        if (due_now) void'(q.pop_front());
        if (rst) begin
            q.delete();
            rr_m   = 0;
            err_m  = '0;
            stat_m = '0;
        end else if (k >= 0) begin
            a = mem_addr[k*64 +: 64];
            d = mem_wdata[k*64 +: 64];
            rr_m = (k + 1) % NC;
`ifdef MEM_RESP_STATS_EN
            stat_m = stat_m + 1;
`endif
            if (a[63:AW+3] != 0) begin
                if (err_m != 32'hFFFF_FFFF) err_m = err_m + 1;
                if (!mem_we[k]) q.push_back('{cyc + LAT, k, 64'd0});
            end else if (mem_we[k]) begin
                mem_m[int'(a[AW+2:3])] = d;
            end else begin
                q.push_back('{cyc + LAT, k, mem_m[int'(a[AW+2:3])]});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        n_chk  = 0;
        n_err  = 0;
        cyc    = 0;
        rr_m   = 0;
        err_m  = '0;
        stat_m = '0;
        rst    = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        req(1, 1'b0, 64'h0, 64'h0);
        step();
        step();
        rst = 1'b0;

        for (int w = 0; w < 16; w++) begin
            idle();
            req(0, 1'b1, 64'(w * 8), {$urandom, $urandom});
            step();
        end

        idle(); req(0, 1'b1, 64'h40, 64'h1122334455667788); step();
        idle(); req(0, 1'b0, 64'h40, 64'h0); step();
        idle(); repeat (3) step();

        repeat (8) begin
            idle();
            for (int c = 0; c < NC; c++) req(c, 1'b0, 64'((c + 1) * 8), 64'h0);
            step();
        end
        idle(); repeat (3) step();

        idle(); req(2, 1'b0, 64'h0000_0001_0000_0000, 64'h0); step();
        idle(); req(2, 1'b1, 64'h0000_0001_0000_0000, 64'hDEAD); step();
        idle(); repeat (3) step();
        chk("err_after_oor", 256'(err_count), 256'(32'd2));
        idle(); req(2, 1'b0, 64'h0, 64'h0); step();
        idle(); repeat (3) step();

        idle(); req(1, 1'b1, 64'h8, 64'hAA); step();
        idle(); req(3, 1'b0, 64'hF, 64'h0); step();
        idle(); repeat (3) step();

        idle(); req(0, 1'b0, 64'h40, 64'h0); step();
        idle(); rst = 1'b1; step();
        rst = 1'b0; repeat (4) step();
        idle(); req(2, 1'b0, 64'h10, 64'h0); req(0, 1'b0, 64'h18, 64'h0); step();
        idle(); repeat (3) step();

        repeat (400) begin
            idle();
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 1) == 1) begin
                    req(c, $urandom_range(0, 3) == 0, rand_addr(),
                        {$urandom, $urandom});
                end
            end
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        idle();
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
